// File: rtl/mmio_dram_gen.sv
// Word-addressed data RAM with a memory-mapped I/O window: synchronised input ports,
// R/W output registers, sticky change flags (W1C), interrupt mask and IRQ.
module mmio_dram_gen #(
  parameter int unsigned DW      = 8,
  parameter int unsigned AW      = 8,
  parameter int unsigned NIN     = 3,
  parameter int unsigned NOUT    = 4,
  parameter int unsigned IO_BASE = 'hF0
) (
  input  logic                CLK,
  input  logic                RESET_L,
  input  logic [AW-1:0]       ADDR,
  input  logic [DW-1:0]       DATA,
  input  logic                MW,
  output logic [DW-1:0]       Q,
  input  logic [NIN*DW-1:0]   IN_BUS,
  output logic [NOUT*DW-1:0]  OUT_BUS,
  output logic [NIN-1:0]      CHG,
  output logic                IRQ
);

  localparam int unsigned OutBase  = IO_BASE + NIN;
  localparam int unsigned StatAddr = OutBase + NOUT;
  localparam int unsigned MaskAddr = StatAddr + 1;
  localparam int unsigned RamAw    = (IO_BASE > 1) ? $clog2(IO_BASE) : 1;

  generate
    if ((MaskAddr + 1 > (1 << AW)) || (NIN < 1) || (NIN > DW) || (NOUT < 1) ||
        (NOUT > DW) || (IO_BASE < 1) || (RamAw > AW)) begin : g_bad_params
      $error("mmio_dram_gen: illegal parameter combination");
    end
  endgenerate

  logic [DW-1:0]      ram_q [IO_BASE];
  logic [NIN*DW-1:0]  sync1_q, sync2_q, prev_q;
  logic [NIN-1:0]     chg_q, chg_d, chg_set, chg_clr;
  logic [NIN-1:0]     mask_q, mask_d;
  logic [NOUT*DW-1:0] out_q, out_d;

  logic               is_ram, is_stat, is_mask;
  logic [NIN-1:0]     in_sel;
  logic [NOUT-1:0]    out_sel;
  logic [RamAw-1:0]   ram_idx;

  assign ram_idx = ADDR[RamAw-1:0];

  always_comb begin
    is_ram  = (ADDR < AW'(IO_BASE));
    is_stat = (ADDR == AW'(StatAddr));
    is_mask = (ADDR == AW'(MaskAddr));
    for (int unsigned i = 0; i < NIN; i++) begin
      in_sel[i] = (ADDR == AW'(IO_BASE + i));
    end
    for (int unsigned j = 0; j < NOUT; j++) begin
      out_sel[j] = (ADDR == AW'(OutBase + j));
    end
  end

  // Read mux: unmapped I/O addresses fall through to zero.
  always_comb begin
    Q = '0;
    if (is_ram) begin
      Q = ram_q[ram_idx];
    end
    for (int unsigned i = 0; i < NIN; i++) begin
      if (in_sel[i]) Q = sync2_q[i*DW +: DW];
    end
    for (int unsigned j = 0; j < NOUT; j++) begin
      if (out_sel[j]) Q = out_q[j*DW +: DW];
    end
    if (is_stat) Q[NIN-1:0] = chg_q;
    if (is_mask) Q[NIN-1:0] = mask_q;
  end

  // A set on the same edge as a W1C clear wins.
  always_comb begin
    for (int unsigned i = 0; i < NIN; i++) begin
      chg_set[i] = (sync2_q[i*DW +: DW] != prev_q[i*DW +: DW]);
    end
    chg_clr = (MW && is_stat) ? DATA[NIN-1:0] : '0;
    chg_d   = (chg_q & ~chg_clr) | chg_set;
    mask_d  = (MW && is_mask) ? DATA[NIN-1:0] : mask_q;
    out_d   = out_q;
    for (int unsigned j = 0; j < NOUT; j++) begin
      if (MW && out_sel[j]) out_d[j*DW +: DW] = DATA;
    end
  end

  // RAM is deliberately outside the reset domain so contents survive reset.
  always_ff @(posedge CLK) begin
    if (RESET_L && MW && is_ram) begin
      ram_q[ram_idx] <= DATA;
    end
  end

  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      chg_q   <= '0;
      mask_q  <= '0;
      out_q   <= '0;
    end else begin
      sync1_q <= IN_BUS;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      chg_q   <= chg_d;
      mask_q  <= mask_d;
      out_q   <= out_d;
    end
  end

  assign OUT_BUS = out_q;
  assign CHG     = chg_q;
  assign IRQ     = |(chg_q & mask_q);

endmodule

// File: tb/tb_mmio_dram_gen.sv
// Directed bench for mmio_dram_gen: memory-map model checked every cycle plus literal checks.
`timescale 1ns/1ps
module tb_mmio_dram_gen;

  localparam int DW      = 8;
  localparam int AW      = 8;
  localparam int NIN     = 3;
  localparam int NOUT    = 4;
  localparam int IO_BASE = 'hF0;
  localparam int OB      = IO_BASE + NIN;
  localparam int ST      = OB + NOUT;
  localparam int MK      = ST + 1;

  logic                CLK = 1'b0;
  logic                RESET_L;
  logic [AW-1:0]       ADDR;
  logic [DW-1:0]       DATA;
  logic                MW;
  logic [DW-1:0]       Q;
  logic [NIN*DW-1:0]   IN_BUS;
  logic [NOUT*DW-1:0]  OUT_BUS;
  logic [NIN-1:0]      CHG;
  logic                IRQ;

  mmio_dram_gen #(
    .DW(DW), .AW(AW), .NIN(NIN), .NOUT(NOUT), .IO_BASE(IO_BASE)
  ) dut (
    .CLK(CLK), .RESET_L(RESET_L), .ADDR(ADDR), .DATA(DATA), .MW(MW), .Q(Q),
    .IN_BUS(IN_BUS), .OUT_BUS(OUT_BUS), .CHG(CHG), .IRQ(IRQ)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;
  bit run = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: IN_BUS samples go through a delay line; the port value seen by software is the
  // sample two edges old, and a flag sets when that visible value differs from the one before.
  logic [DW-1:0]       m_ram  [IO_BASE];
  bit                  m_ramv [IO_BASE];
  logic [NIN*DW-1:0]   h1 = '0, h2 = '0, h3 = '0;
  logic [NIN-1:0]      m_chg = '0, m_mask = '0, m_set, m_clr;
  logic [NOUT*DW-1:0]  m_out = '0;

  always @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      h1 = '0; h2 = '0; h3 = '0;
      m_chg = '0; m_mask = '0; m_out = '0;
    end else begin
      int a;
      a = int'(ADDR);
      m_clr = '0;
      for (int i = 0; i < NIN; i++) m_set[i] = (h2[i*DW +: DW] != h3[i*DW +: DW]);
      if (MW) begin
        if (a < IO_BASE) begin
          m_ram[a] = DATA; m_ramv[a] = 1'b1;
        end else if (a >= OB && a < ST) begin
          m_out[(a-OB)*DW +: DW] = DATA;
        end else if (a == ST) begin
          m_clr = DATA[NIN-1:0];
        end else if (a == MK) begin
          m_mask = DATA[NIN-1:0];
        end
      end
      m_chg = (m_chg & ~m_clr) | m_set;
      h3 = h2; h2 = h1; h1 = IN_BUS;
    end
  end

  function automatic logic [DW-1:0] exp_q(input int a, output bit known);
    known = 1'b1;
    if (a < IO_BASE) begin
      known = m_ramv[a];
      return m_ram[a];
    end
    if (a < OB) return h2[(a-IO_BASE)*DW +: DW];
    if (a < ST) return m_out[(a-OB)*DW +: DW];
    if (a == ST) return DW'(m_chg);
    if (a == MK) return DW'(m_mask);
    return '0;
  endfunction

  always @(negedge CLK) begin
    if (run) begin
      logic [DW-1:0] e;
      bit k;
      e = exp_q(int'(ADDR), k);
      if (k) chk("model_q", Q, e);
      chk("model_out_bus", OUT_BUS, m_out);
      chk("model_chg", CHG, m_chg);
      chk("model_irq", IRQ, |(m_chg & m_mask));
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wr(input int a, input int d);
    ADDR = AW'(a); DATA = DW'(d); MW = 1'b1;
    tick();
    MW = 1'b0;
  endtask

  task automatic rd(input string name, input int a, input int exp);
    ADDR = AW'(a);
    #1;
    chk(name, Q, 64'(exp));
  endtask

  initial begin
    RESET_L = 1'b1; MW = 1'b0; ADDR = '0; DATA = '0; IN_BUS = '0;
    #1 RESET_L = 1'b0;
    run = 1'b1;
    tick(); tick();
    chk("rst_out_bus", OUT_BUS, 0);
    chk("rst_chg", CHG, 0);
    chk("rst_irq", IRQ, 0);
    RESET_L = 1'b1;

    // RAM
    wr('h10, 'hA5);
    rd("ram_rd", 'h10, 'hA5);
    wr('h11, 'h5A);
    rd("ram_neighbour", 'h10, 'hA5);
    rd("ram_rd2", 'h11, 'h5A);

    // Output registers and asynchronous reset
    wr(OB + 1, 'h3C);
    chk("out_bus_port1", OUT_BUS, 64'('h3C) << DW);
    rd("out_rd", OB + 1, 'h3C);
    RESET_L = 1'b0;
    #1;
    chk("async_rst_out", OUT_BUS, 0);
    ADDR = AW'('h10); DATA = '0; MW = 1'b1;
    tick();
    MW = 1'b0;
    RESET_L = 1'b1;
    rd("ram_retained", 'h10, 'hA5);

    // Input synchronisation and change detection
    IN_BUS[0 +: DW] = 'h5A;
    IN_BUS[DW +: DW] = 'h11;
    ADDR = AW'(IO_BASE);
    tick();
    chk("sync_edge1", Q, 'h00);
    tick();
    chk("sync_edge2", Q, 'h5A);
    chk("chg_edge2", CHG, 0);
    tick();
    chk("chg_edge3", CHG, 'b011);
    wr(IO_BASE, 'hFF);
    rd("in_ro", IO_BASE, 'h5A);

    // Mask, IRQ, W1C and set priority
    wr(MK, 'b010);
    chk("irq_on", IRQ, 1);
    rd("mask_rd", MK, 'b010);
    wr(ST, 'b010);
    chk("w1c_chg", CHG, 'b001);
    chk("w1c_irq", IRQ, 0);
    IN_BUS[0 +: DW] = 'hA5;
    tick(); tick();
    wr(ST, 'b001);
    chk("set_wins", CHG, 'b001);
    wr(ST, 'b001);
    chk("w1c_bit0", CHG, 'b000);
    rd("stat_rd", ST, 0);

    // Unmapped window
    for (int a = MK + 1; a < (1 << AW); a++) rd("unmapped_rd", a, 0);
    wr(MK + 2, 'hFF);
    chk("unmapped_out", OUT_BUS, 0);
    chk("unmapped_chg", CHG, 0);
    rd("unmapped_mask", MK, 'b010);
    rd("unmapped_ram", 'h10, 'hA5);

    // Reset release with inputs held nonzero
    RESET_L = 1'b0;
    #1;
    RESET_L = 1'b1;
    tick(); tick();
    chk("rel_chg_edge2", CHG, 0);
    tick();
    chk("rel_chg_edge3", CHG, 'b011);
    chk("rel_irq_masked", IRQ, 0);
    tick(); tick();

    run = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mmio_dram_gen.md
Name: mmio_dram_gen

Overview:
Parametrised successor to the lab data memory. It combines a word-addressed data RAM with a memory-mapped I/O window. The window holds configurable counts of synchronised input ports and read/write output ports, plus a sticky change-flag register, an interrupt mask and an IRQ output. It sits between the cpu data port (address from DataD, write data from DataB, read data to Din) and the board I/O.

Parameters:
DW, 8, data/word width in bits
AW, 8, address width; address space is 2^AW words
NIN, 3, number of input ports (1..DW)
NOUT, 4, number of output ports (1..DW)
IO_BASE, 8'hF0, first I/O address; RAM occupies 0..IO_BASE-1
Legal only if IO_BASE + NIN + NOUT + 2 <= 2^AW; elaboration fails otherwise.

Ports:
CLK  input  1  system clock, rising edge
RESET_L  input  1  asynchronous active-low reset
ADDR  input  AW  word address
DATA  input  DW  write data
MW  input  1  memory write enable, sampled on rising CLK
Q  output  DW  read data, combinational from ADDR and current state
IN_BUS  input  NIN*DW  input ports; port i = IN_BUS[i*DW +: DW]; asynchronous to CLK
OUT_BUS  output  NIN*DW → NOUT*DW  output port registers; port j = OUT_BUS[j*DW +: DW]
CHG  output  NIN  sticky change flags
IRQ  output  1  |(CHG & MASK[NIN-1:0]), registered-state derived, no glitch path from ADDR

Behaviour:
- Memory map:
  - ADDR < IO_BASE: RAM.
  - IO_BASE+i (i<NIN): input port i, read-only.
  - IO_BASE+NIN+j (j<NOUT): output reg j, R/W.
  - STAT = IO_BASE+NIN+NOUT: CHG flags, W1C.
  - MASKA = STAT+1: MASK, R/W.
  - Any other address >= IO_BASE reads 0; writes to it are ignored.
- Reads: Q = selected word. STAT and MASK are zero-extended to DW. Input port reads return the synchronised value (sync2), not raw IN_BUS.
- Writes: on rising CLK when MW=1 and RESET_L=1.
  - RAM: RAM[ADDR] <= DATA.
  - Output reg j <= DATA.
  - MASK <= DATA[NIN-1:0].
  - STAT: CHG <= CHG & ~DATA[NIN-1:0], subject to the set-priority rule below.
  - Writes to input-port addresses are ignored.
  - Q reflects a write from the edge after that edge (no write-through on the same cycle).
- Input synchronisation: two-flop chain per port, sync1 <= IN_BUS, sync2 <= sync1. A stable input change is visible on Q two rising edges later.
- Change detection:
  - prev_i <= sync2_i every cycle.
  - CHG[i] sets on the edge where sync2_i != prev_i, i.e. the third edge after the input change.
  - Flags are sticky until cleared by W1C.
- Simultaneous set and W1C clear on the same bit in the same cycle: set wins, and the flag remains 1.
- IRQ is combinational from CHG and MASK registers. It asserts the same cycle CHG/MASK update.
- Reset (RESET_L=0, asynchronous, any time including mid-write):
  - OUT_BUS=0, CHG=0, MASK=0, IRQ=0.
  - sync1, sync2 and prev all clear to 0.
  - RAM contents are not reset and are retained across reset.
  - No write occurs on an edge while RESET_L=0.
- After reset release: inputs held at a nonzero value produce a CHG set on the third edge (0→value transition). This is required behaviour; software clears it with W1C.
- All arithmetic is address comparison only; there is no wrap-around within the map. An ADDR beyond MASKA is unmapped.

Test Plan:
- RAM: write 8'hA5 to addr 8'h10 (MW=1, one edge), then set MW=0 and ADDR=8'h10 → Q=8'hA5. Write to 8'h11 leaves 8'h10 unchanged. Assert RESET_L low then high → Q at 8'h10 is still 8'hA5.
- Outputs: write 8'h3C to IO_BASE+NIN+1 (8'hF4) → OUT_BUS[15:8]=8'h3C, other ports 0, reading 8'hF4 gives 8'h3C. Async reset mid-cycle → OUT_BUS=0 immediately, without waiting for a clock edge.
- Input sync: drive IN_BUS port 0 from 8'h00 to 8'h5A between edges → Q at 8'hF0 is 8'h00 after edge 1 and 8'h5A after edge 2. CHG[0]=1 after edge 3. Write to 8'hF0 is ignored.
- W1C/IRQ: with CHG=3'b011, write MASK=3'b010 → IRQ=1. Write STAT with 3'b010 → CHG=3'b001, IRQ=0. Write STAT with 3'b001 on the same edge that port 0 changes again → CHG[0] remains 1.
- Unmapped: read 8'hF9..8'hFF → Q=0. Write 8'hFF to 8'hFA → no state change anywhere.
- Parameter sweep: DW=16, AW=10, NIN=1, NOUT=8, IO_BASE=10'h3F0 → repeat the tests above at the scaled addresses with the same results.
